// File: rtl/sub_slice_sequencer.sv
// Multi-cycle wide subtractor that reuses one 3-bit ripple-borrow slice,
// LSB slice first, with a valid/ready handshake on both sides.

module full_sub_3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       bi,
    output logic [2:0] sub,
    output logic       bo
);
    logic [3:0] chain;

    always_comb begin
        chain    = '0;
        chain[0] = bi;
        sub      = '0;
        for (int i = 0; i < 3; i++) begin
            sub[i]       = a[i] ^ b[i] ^ chain[i];
            chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
        end
        bo = chain[3];
    end
endmodule

module sub_slice_sequencer #(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*NSLICE-1:0]   a,
    input  logic [3*NSLICE-1:0]   b,
    input  logic                  bi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*NSLICE-1:0]   diff,
    output logic                  bo
);
    localparam int W  = 3 * NSLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          bi_reg;
    logic          borrow_reg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  diff_acc;

    logic [2:0]    slice_a;
    logic [2:0]    slice_b;
    logic          slice_bi;
    logic [2:0]    slice_sub;
    logic          slice_bo;
    logic [W-1:0]  merged;
    int            idx;

    assign in_ready = (state == IDLE);

    // Select the active 3-bit window and fold the new slice result into the accumulator.
    always_comb begin
        idx      = int'(cnt);
        slice_a  = a_reg[3*idx +: 3];
        slice_b  = b_reg[3*idx +: 3];
        slice_bi = (cnt == '0) ? bi_reg : borrow_reg;
        merged   = diff_acc;
        merged[3*idx +: 3] = slice_sub;
    end

    full_sub_3bit u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .bi  (slice_bi),
        .sub (slice_sub),
        .bo  (slice_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            bi_reg     <= 1'b0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            diff_acc   <= '0;
            diff       <= '0;
            bo         <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        bi_reg <= bi;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff_acc   <= merged;
                    borrow_reg <= slice_bo;
                    if (cnt == LAST) begin
                        diff      <= merged;
                        bo        <= slice_bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it; no new accept here.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_slice_sequencer.sv
// Directed and randomized checks of sub_slice_sequencer with NSLICE=4 (12-bit operands).

module tb_sub_slice_sequencer;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        bi;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] diff;
    logic        bo;

    int checks = 0;
    int errors = 0;

    sub_slice_sequencer #(.NSLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bo        (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        bi;
        logic [11:0] ediff;
        logic        ebo;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, then presents one operand set for exactly the accept edge.
    task automatic applyStimulus(input logic [11:0] va, input logic [11:0] vb, input logic vbi);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("in_ready before accept", {31'b0, in_ready}, 1);
        a        = va;
        b        = vb;
        bi       = vbi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        checkOutput("out_valid arrives", {31'b0, out_valid}, 1);
    endtask

    task automatic runOp(input logic [11:0] va, input logic [11:0] vb, input logic vbi,
                         input logic [11:0] ed, input logic eb, input string name);
        int lat;
        out_ready = 1'b1;
        applyStimulus(va, vb, vbi);
        waitResult(lat);
        checkOutput({name, ".latency"}, lat, 4);
        checkOutput({name, ".diff"}, {20'b0, diff}, {20'b0, ed});
        checkOutput({name, ".bo"}, {31'b0, bo}, {31'b0, eb});
        tick();
        checkOutput({name, ".pulse"}, {31'b0, out_valid}, 0);
        checkOutput({name, ".in_ready"}, {31'b0, in_ready}, 1);
    endtask

    function automatic logic [12:0] model(input logic [11:0] ma, input logic [11:0] mb, input logic mbi);
        return {1'b0, ma} - {1'b0, mb} - {12'b0, mbi};
    endfunction

    initial begin
        int lat;
        int cyc;
        int acc;
        int last_acc;
        logic [12:0] q[$];
        logic [12:0] r;

        vecs[0] = '{12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, "msb_borrow"};
        vecs[1] = '{12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1, "bi_ripple"};
        vecs[2] = '{12'h123, 12'h456, 1'b0, 12'hCCD, 1'b1, "neg_result"};
        vecs[3] = '{12'hFFF, 12'hFFF, 1'b0, 12'h000, 1'b0, "equal"};
        vecs[4] = '{12'hABC, 12'h123, 1'b0, 12'h999, 1'b0, "no_borrow"};
        vecs[5] = '{12'h555, 12'hAAA, 1'b0, 12'hAAB, 1'b1, "alt_bits"};
        vecs[6] = '{12'h000, 12'hFFF, 1'b1, 12'h000, 1'b1, "max_sub"};
        vecs[7] = '{12'hFFF, 12'h000, 1'b1, 12'hFFE, 1'b0, "max_min_bi"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bi        = 1'b0;
        #12;
        checkOutput("reset.out_valid", {31'b0, out_valid}, 0);
        checkOutput("reset.diff", {20'b0, diff}, 0);
        checkOutput("reset.bo", {31'b0, bo}, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("reset.in_ready", {31'b0, in_ready}, 1);

        for (int i = 0; i < 8; i++)
            runOp(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].ediff, vecs[i].ebo, vecs[i].name);

        // Backpressure hold with operands scrambled during RUN.
        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        applyStimulus(12'h123, 12'h456, 1'b0);
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 30) begin
            a  = 12'($urandom);
            b  = 12'($urandom);
            bi = 1'($urandom);
            tick();
            lat++;
        end
        checkOutput("stall.latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall.out_valid", {31'b0, out_valid}, 1);
            checkOutput("stall.diff", {20'b0, diff}, 32'hCCD);
            checkOutput("stall.bo", {31'b0, bo}, 1);
            checkOutput("stall.in_ready", {31'b0, in_ready}, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("stall.release", {31'b0, out_valid}, 0);
        checkOutput("stall.diff_kept", {20'b0, diff}, 32'hCCD);

        // Reset pulse during RUN cycle 2 aborts the operation.
        $display("[TB] mid-run reset sequence");
        applyStimulus(12'h7AB, 12'h123, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checkOutput("abort.out_valid", {31'b0, out_valid}, 0);
        checkOutput("abort.diff", {20'b0, diff}, 0);
        checkOutput("abort.bo", {31'b0, bo}, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("abort.in_ready", {31'b0, in_ready}, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("abort.no_valid", {31'b0, out_valid}, 0);
        end
        runOp(12'h00A, 12'h003, 1'b0, 12'h007, 1'b0, "after_abort");

        // Back-to-back accepts with in_valid held high.
        $display("[TB] back-to-back sequence");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a  = 12'($urandom);
        b  = 12'($urandom);
        bi = 1'($urandom);
        cyc = 0;
        acc = 0;
        last_acc = -1;
        while ((acc < 5 || q.size() != 0) && cyc < 100) begin
            logic accepting;
            accepting = 1'b0;
            if (out_valid) begin
                r = (q.size() != 0) ? q.pop_front() : 13'h0;
                checkOutput("b2b.diff", {20'b0, diff}, {20'b0, r[11:0]});
                checkOutput("b2b.bo", {31'b0, bo}, {31'b0, r[12]});
            end
            if (in_ready && in_valid) begin
                if (last_acc >= 0)
                    checkOutput("b2b.spacing", cyc - last_acc, 6);
                last_acc = cyc;
                q.push_back(model(a, b, bi));
                acc++;
                accepting = 1'b1;
            end
            tick();
            cyc++;
            if (accepting) begin
                a  = 12'($urandom);
                b  = 12'($urandom);
                bi = 1'($urandom);
                if (acc == 5)
                    in_valid = 1'b0;
            end
        end
        checkOutput("b2b.accepts", acc, 5);
        checkOutput("b2b.drained", q.size(), 0);

        // Random vectors with random output backpressure.
        $display("[TB] random sequence");
        for (int i = 0; i < 1000; i++) begin
            logic [11:0] ra;
            logic [11:0] rb;
            logic        rbi;
            bit          seen;
            bit          done;
            int          n;
            ra  = 12'($urandom);
            rb  = 12'($urandom);
            rbi = 1'($urandom);
            r   = model(ra, rb, rbi);
            applyStimulus(ra, rb, rbi);
            seen = 0;
            done = 0;
            n    = 0;
            while (!done && n < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid) begin
                    if (!seen) begin
                        checkOutput("rand.diff", {20'b0, diff}, {20'b0, r[11:0]});
                        checkOutput("rand.bo", {31'b0, bo}, {31'b0, r[12]});
                        seen = 1;
                    end
                    if (out_ready)
                        done = 1;
                end
                tick();
                n++;
            end
            checkOutput("rand.completed", {31'b0, done}, 1);
        end
        out_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
